// File: rtl/tri_scan_drv_pkg.sv
// Shared constants for the scan ring driver.
package tri_scan_drv_pkg;

    localparam int unsigned StateW = 2;

endpackage

// File: rtl/tri_scan_drv.sv
// Scan ring driver: shifts a parallel word into a serial latch ring while
// collecting the ring's previous contents from its tail.
module tri_scan_drv
    import tri_scan_drv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             nclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             hold,
    input  logic [0:WIDTH-1] wr_data,
    output logic [0:WIDTH-1] rd_data,
    output logic             busy,
    output logic             done,
    output logic             scan_en,
    output logic             scan_out,
    input  logic             scan_in
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(WIDTH - 1);

    localparam logic [StateW-1:0] StIdle  = 2'd0;
    localparam logic [StateW-1:0] StShift = 2'd1;
    localparam logic [StateW-1:0] StDone  = 2'd2;

    logic [StateW-1:0] state_q, state_d;
    logic [0:WIDTH-1]  sr_q, sr_d;
    logic [0:WIDTH-1]  sr_shift;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              in_shift;

    assign in_shift = (state_q == StShift);

    // Tail bit enters at sr[0] so that bit order matches the ring after WIDTH shifts.
    always_comb begin
        sr_shift    = sr_q;
        sr_shift[0] = scan_in;
        for (int unsigned i = 1; i < WIDTH; i++) begin
            sr_shift[i] = sr_q[i-1];
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    sr_d    = wr_data;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (!hold) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntMax) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge nclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign scan_en  = in_shift & ~hold;
    assign scan_out = in_shift & sr_q[WIDTH-1];
    assign rd_data  = sr_q;

endmodule

// File: tb/tb_tri_scan_drv.sv
// Bench for tri_scan_drv: ring models on WIDTH=8 and WIDTH=1 instances, a
// scoreboard of expected results checked on each done pulse.
module tb_tri_scan_drv;

    logic       nclk = 1'b0;
    logic       rst_n;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 nclk = ~nclk;

    // WIDTH=8 instance with its ring model
    logic       start8, hold8, busy8, done8, scan_en8, scan_out8, scan_in8;
    logic [0:7] wr8, rd8, ring8, load_val8;
    logic       load8;

    tri_scan_drv #(.WIDTH(8)) dut8 (
        .nclk     (nclk),
        .rst_n    (rst_n),
        .start    (start8),
        .hold     (hold8),
        .wr_data  (wr8),
        .rd_data  (rd8),
        .busy     (busy8),
        .done     (done8),
        .scan_en  (scan_en8),
        .scan_out (scan_out8),
        .scan_in  (scan_in8)
    );

    always @(posedge nclk) begin
        if (load8) ring8 <= load_val8;
        else if (scan_en8) ring8 <= {scan_out8, ring8[0:6]};
    end
    assign scan_in8 = ring8[7];

    // WIDTH=1 instance with its ring model
    logic       start1, hold1, busy1, done1, scan_en1, scan_out1, scan_in1;
    logic [0:0] wr1, rd1;
    logic       ring1, load1, load_val1;

    tri_scan_drv #(.WIDTH(1)) dut1 (
        .nclk     (nclk),
        .rst_n    (rst_n),
        .start    (start1),
        .hold     (hold1),
        .wr_data  (wr1),
        .rd_data  (rd1),
        .busy     (busy1),
        .done     (done1),
        .scan_en  (scan_en1),
        .scan_out (scan_out1),
        .scan_in  (scan_in1)
    );

    always @(posedge nclk) begin
        if (load1) ring1 <= load_val1;
        else if (scan_en1) ring1 <= scan_out1;
    end
    assign scan_in1 = ring1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: expected {rd_data, ring} pushed at acceptance, popped on done.
    typedef struct packed {
        logic [7:0] rd;
        logic [7:0] ring;
    } exp_t;
    exp_t sb[$];

    always @(negedge nclk) begin
        #1;
        if (done8 === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", {24'd0, rd8}, {24'd0, e.rd});
                check("ring", {24'd0, ring8}, {24'd0, e.ring});
            end
        end
    end

    typedef struct {
        logic [7:0] ring_init;
        logic [7:0] wr;
        int         hold_at;
        int         hold_len;
        bit         start_mid;
        logic [7:0] exp_rd;
        logic [7:0] exp_ring;
        int         exp_lat;
    } vec_t;

    task automatic do_op(input vec_t v);
        int cyc, en, lo;
        bit got;
        @(negedge nclk);
        load8 = 1'b1; load_val8 = v.ring_init; start8 = 1'b1; wr8 = v.wr;
        @(negedge nclk);
        load8 = 1'b0; start8 = 1'b0;
        sb.push_back('{rd: v.exp_rd, ring: v.exp_ring});
        cyc = 1; en = 0; lo = 0; got = 1'b0;
        while (cyc < 100 && !got) begin
            hold8  = (cyc >= v.hold_at) && (cyc < v.hold_at + v.hold_len);
            start8 = v.start_mid && (cyc == 3);
            #1;
            if (done8) begin
                got = 1'b1;
            end else begin
                if (scan_en8) en++;
                else lo++;
                @(negedge nclk);
                cyc++;
            end
        end
        hold8 = 1'b0; start8 = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        check("latency", cyc, v.exp_lat);
        check("scan_en_cycles", en, 8);
        check("stall_cycles", lo, v.hold_len);
        check("busy_in_done", {31'd0, busy8}, 32'd1);
        if (v.start_mid) start8 = 1'b1;
        @(negedge nclk);
        start8 = 1'b0;
        #1;
        check("done_one_cycle", {31'd0, done8}, 32'd0);
        check("idle_after_done", {31'd0, busy8}, 32'd0);
        repeat (2) @(negedge nclk);
        #1;
        check("no_extra_op", {31'd0, busy8}, 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int   t2;
        bit   prev_busy;

        rst_n = 1'b0;
        start8 = 0; hold8 = 0; wr8 = '0; load8 = 0; load_val8 = '0;
        start1 = 0; hold1 = 0; wr1 = '0; load1 = 0; load_val1 = 0;
        #1;
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_rd", {24'd0, rd8}, 32'd0);
        check("rst_scan_en", {31'd0, scan_en8}, 32'd0);
        check("rst_done1", {31'd0, done1}, 32'd0);
        @(negedge nclk);
        rst_n = 1'b1;

        vecs[0] = '{8'hA5, 8'h3C, 0, 0, 1'b0, 8'hA5, 8'h3C, 9};
        vecs[1] = '{8'hA5, 8'h3C, 5, 3, 1'b0, 8'hA5, 8'h3C, 12};
        vecs[2] = '{8'h3C, 8'hC3, 0, 0, 1'b1, 8'h3C, 8'hC3, 9};
        vecs[3] = '{8'hFF, 8'h00, 1, 2, 1'b0, 8'hFF, 8'h00, 11};
        vecs[4] = '{8'h01, 8'h80, 2, 1, 1'b1, 8'h01, 8'h80, 10};
        for (int i = 0; i < 5; i++) do_op(vecs[i]);

        // Back-to-back with start held high
        @(negedge nclk);
        load8 = 1'b1; load_val8 = 8'hA5; start8 = 1'b1; wr8 = 8'h3C;
        @(negedge nclk);
        load8 = 1'b0;
        sb.push_back('{rd: 8'hA5, ring: 8'h3C});
        #1;
        check("b2b_first_busy", {31'd0, busy8}, 32'd1);
        wr8 = 8'hFF;
        prev_busy = 1'b1; t2 = 0;
        for (int c = 2; c < 40 && t2 == 0; c++) begin
            @(negedge nclk);
            #1;
            if (!prev_busy && busy8) begin
                t2 = c;
                sb.push_back('{rd: 8'h3C, ring: 8'hFF});
                start8 = 1'b0;
            end
            prev_busy = busy8;
        end
        start8 = 1'b0;
        check("b2b_period", t2 - 1, 10);
        for (int c = 0; c < 30 && !done8; c++) begin
            @(negedge nclk);
            #1;
        end
        repeat (3) @(negedge nclk);

        // Reset after the 5th shift: no done for the interrupted op
        @(negedge nclk);
        load8 = 1'b1; load_val8 = 8'hA5; start8 = 1'b1; wr8 = 8'h3C;
        @(negedge nclk);
        load8 = 1'b0; start8 = 1'b0;
        sb.push_back('{rd: 8'hA5, ring: 8'h3C});
        repeat (5) @(negedge nclk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_done", {31'd0, done8}, 32'd0);
        check("midrst_scan_en", {31'd0, scan_en8}, 32'd0);
        check("midrst_scan_out", {31'd0, scan_out8}, 32'd0);
        check("midrst_rd", {24'd0, rd8}, 32'd0);
        sb.delete();
        @(negedge nclk);
        rst_n = 1'b1;
        repeat (12) @(negedge nclk);
        do_op('{8'h00, 8'h81, 0, 0, 1'b0, 8'h00, 8'h81, 9});

        // WIDTH=1
        @(negedge nclk);
        load1 = 1'b1; load_val1 = 1'b1; start1 = 1'b1; wr1 = 1'b0;
        @(negedge nclk);
        load1 = 1'b0; start1 = 1'b0;
        #1;
        check("w1_scan_en", {31'd0, scan_en1}, 32'd1);
        check("w1_scan_out", {31'd0, scan_out1}, 32'd0);
        @(negedge nclk);
        #1;
        check("w1_done", {31'd0, done1}, 32'd1);
        check("w1_rd", {31'd0, rd1}, 32'd1);
        check("w1_ring", {31'd0, ring1}, 32'd0);
        @(negedge nclk);
        #1;
        check("w1_done_clear", {31'd0, done1}, 32'd0);
        check("w1_idle", {31'd0, busy1}, 32'd0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
